nor_gate: RTL and testbench

- Parameterized bitwise two-input NOR primitive for the basic-gates library.
- Combinational output `Out = ~(A | B)` per bit, with zero latency.
- Also provides a registered copy with a valid flag, a reduction flag, and a saturating count of all-ones cycles, so one block serves both glue logic and pipelined datapaths.

---
 rtl/nor_gate_pkg.sv | 12 +
 rtl/nor_gate_if.sv | 29 ++
 rtl/nor_gate_out_reg.sv | 37 +++
 rtl/nor_gate.sv | 51 +++++
 tb/tb_nor_gate.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/nor_gate_pkg.sv
// Shared definitions for the basic-gates library: default widths and the
// saturating increment used by every gate block that keeps a hit counter.
package gates_pkg;

  localparam int GATE_W_DEFAULT     = 1;
  localparam int GATE_CNT_W_DEFAULT = 8;

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max);
    return (value >= max) ? max : value + 1;
  endfunction

endpackage

// File: rtl/nor_gate_if.sv
// Operand/result bundle for a two-input gate block; master drives operands,
// slave (the gate) drives the combinational and registered results.
interface nor_gate_if
  import gates_pkg::*;
#(
  parameter int WIDTH = GATE_W_DEFAULT,
  parameter int CNT_W = GATE_CNT_W_DEFAULT
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] out_q;
  logic             out_valid;
  logic             all_ones;
  logic [CNT_W-1:0] hit_count;

  modport master (
    output A, B, in_valid,
    input  Out, out_q, out_valid, all_ones, hit_count
  );

  modport slave (
    input  A, B, in_valid,
    output Out, out_q, out_valid, all_ones, hit_count
  );

endinterface

// File: rtl/nor_gate_out_reg.sv
// Valid-qualified result register shared by the gate blocks: holds the last
// accepted result, pulses valid for one cycle per accept, and flags all-ones.
module gate_out_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_all_ones
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_all_ones;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_all_ones <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data     <= i_data;
        r_all_ones <= &i_data;
      end
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_all_ones = r_all_ones;

endmodule

// File: rtl/nor_gate.sv
// Bitwise two-input NOR with a zero-latency output, a 1-cycle registered copy
// with valid/all-ones flags, and a saturating count of all-ones results.
module nor_gate
  import gates_pkg::*;
#(
  parameter int WIDTH = GATE_W_DEFAULT,
  parameter int CNT_W = GATE_CNT_W_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  nor_gate_if.slave bus
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
    $error("nor_gate: WIDTH and CNT_W must both be at least 1");
  end

  localparam int unsigned CNT_MAX = 32'({CNT_W{1'b1}});

  logic [WIDTH-1:0] w_nor;
  logic             w_hit;
  logic [CNT_W-1:0] r_hit_count;

  assign w_nor   = ~(bus.A | bus.B);
  assign w_hit   = bus.in_valid & (&w_nor);
  assign bus.Out = w_nor;

  gate_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (bus.in_valid),
    .i_data     (w_nor),
    .o_data     (bus.out_q),
    .o_valid    (bus.out_valid),
    .o_all_ones (bus.all_ones)
  );

  // Counter sticks at its maximum rather than wrapping back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count <= '0;
    end else if (w_hit) begin
      r_hit_count <= CNT_W'(sat_inc(32'(r_hit_count), CNT_MAX));
    end
  end

  assign bus.hit_count = r_hit_count;

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench: WIDTH=1 truth-table sweep, hand-written registered-path
// sequences at WIDTH=4/CNT_W=2, then randomized traffic against a reference model.
module tb_nor_gate;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nor_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
  nor_gate_if #(.WIDTH(4), .CNT_W(2)) bus4 ();

  nor_gate #(.WIDTH(1), .CNT_W(8)) u_nor1 (.clk(clk), .rst(rst), .bus(bus1));
  nor_gate #(.WIDTH(4), .CNT_W(2)) u_nor4 (.clk(clk), .rst(rst), .bus(bus4));

  typedef struct {
    logic a;
    logic b;
    logic exp_out;
  } vec_t;

  vec_t vecs[8];

  // Reference model state for the WIDTH=4, CNT_W=2 instance
  int m_q, m_all, m_valid, m_hits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b);
    bus4.in_valid = v;
    bus4.A        = a;
    bus4.B        = b;
  endtask

  task automatic edge_wait;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag, input int q, input int v, input int all, input int hits);
    chk({tag, ".out_q"},     32'(bus4.out_q),     32'(q));
    chk({tag, ".out_valid"}, 32'(bus4.out_valid), 32'(v));
    chk({tag, ".all_ones"},  32'(bus4.all_ones),  32'(all));
    chk({tag, ".hit_count"}, 32'(bus4.hit_count), 32'(hits));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 1'b1 ^ 1'b1};

    bus1.in_valid = 1'b0;
    bus1.A = 1'b0;
    bus1.B = 1'b0;
    drive4(1'b0, 4'h0, 4'h0);

    // WIDTH=1 combinational sweep
    for (int i = 0; i < 8; i++) begin
      bus1.A = vecs[i].a;
      bus1.B = vecs[i].b;
      #1;
      chk($sformatf("sweep%0d.Out", i), 32'(bus1.Out), 32'(vecs[i].exp_out));
      $display("sweep %0d: A=%b B=%b Out=%b", i, bus1.A, bus1.B, bus1.Out);
      #4;
    end

    // Reset held for two cycles with a valid all-zero operand pair
    @(negedge clk);
    rst = 1'b1;
    drive4(1'b1, 4'h0, 4'h0);
    for (int i = 0; i < 2; i++) begin
      edge_wait();
      chk_reg($sformatf("reset%0d", i), 0, 0, 0, 0);
      chk($sformatf("reset%0d.Out", i), 32'(bus4.Out), 32'hF);
      $display("reset cycle %0d: out_q=%h out_valid=%b hit_count=%0d", i, bus4.out_q, bus4.out_valid, bus4.hit_count);
    end
    rst = 1'b0;

    // Registered latency
    drive4(1'b1, 4'b0101, 4'b0011);
    #1;
    chk("lat.Out", 32'(bus4.Out), 32'h8);
    edge_wait();
    chk_reg("lat", 8, 1, 0, 0);
    $display("latency: out_q=%h out_valid=%b all_ones=%b", bus4.out_q, bus4.out_valid, bus4.all_ones);

    // all_ones then hold
    drive4(1'b1, 4'h0, 4'h0);
    edge_wait();
    chk_reg("allones", 15, 1, 1, 1);
    drive4(1'b0, 4'hF, 4'h0);
    #1;
    chk("hold.Out", 32'(bus4.Out), 32'h0);
    edge_wait();
    chk_reg("hold", 15, 0, 1, 1);
    $display("hold: out_q=%h out_valid=%b Out=%h", bus4.out_q, bus4.out_valid, bus4.Out);

    // Reset mid-stream
    drive4(1'b1, 4'h0, 4'h0);
    edge_wait();
    chk_reg("run0", 15, 1, 1, 2);
    rst = 1'b1;
    edge_wait();
    chk_reg("midrst", 0, 0, 0, 0);
    $display("mid-stream reset: out_valid=%b hit_count=%0d", bus4.out_valid, bus4.hit_count);
    rst = 1'b0;

    // Saturation at CNT_W=2, resuming straight after reset
    for (int i = 0; i < 5; i++) begin
      edge_wait();
      chk_reg($sformatf("sat%0d", i), 15, 1, 1, (i < 3) ? i + 1 : 3);
      $display("sat %0d: hit_count=%0d", i, bus4.hit_count);
    end

    // Randomized traffic against the reference model
    m_q = 15; m_all = 1; m_valid = 1; m_hits = 3;
    for (int n = 0; n < 300; n++) begin
      int a, b, v, r, res;
      r = ($urandom_range(0, 15) == 0) ? 1 : 0;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      a = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
      b = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 15));
      rst = r[0];
      drive4(v[0], a[3:0], b[3:0]);
      res = 15 - (a | b);
      #1;
      chk("rnd.Out", 32'(bus4.Out), 32'(res));
      if (r == 1) begin
        m_q = 0; m_all = 0; m_valid = 0; m_hits = 0;
      end else if (v == 1) begin
        m_q = res;
        m_all = (res == 15) ? 1 : 0;
        m_valid = 1;
        if (res == 15) m_hits = (m_hits + 1 > 3) ? 3 : m_hits + 1;
      end else begin
        m_valid = 0;
      end
      edge_wait();
      chk_reg("rnd", m_q, m_valid, m_all, m_hits);
      $display("rnd %0d: rst=%0d v=%0d A=%h B=%h out_q=%h valid=%b all=%b hits=%0d",
               n, r, v, a, b, bus4.out_q, bus4.out_valid, bus4.all_ones, bus4.hit_count);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
